// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells: FSM states, default
// word width and counter sizing helper.
package serial_arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } serial_state_t;

  localparam int unsigned SERIAL_WIDTH_DEFAULT = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/one_bit_full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bin with borrow out.
module one_bit_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_full_subtractor.sv
// Bit-serial LSB-first subtractor D = A - B with a registered borrow chain.
// Optional signed overflow output when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_full_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_start,
  input  logic a_bit,
  input  logic b_bit,
  output logic diff_valid,
  output logic diff_bit,
  output logic word_done,
  output logic borrow_out,
  output logic busy
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic overflow
`endif
);

  localparam int unsigned CW = clog2(WIDTH);

  serial_state_t state;
  logic [CW-1:0] cnt;
  logic          borrow_q;

  logic start_bit;
  logic accept;
  logic msb_bit;
  logic bin;
  logic d;
  logic bout;

  // A start bit always opens a new word, even mid-word, so it overrides the
  // MSB decision and the stored borrow.
  always_comb begin
    start_bit = in_valid & in_start;
    accept    = start_bit | (in_valid & (state == RUN));
    msb_bit   = (state == RUN) & ~in_start & (cnt == CW'(WIDTH - 1));
    bin       = start_bit ? 1'b0 : borrow_q;
  end

  one_bit_full_subtractor u_cell (
    .a    (a_bit),
    .b    (b_bit),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      borrow_q   <= 1'b0;
      diff_valid <= 1'b0;
      diff_bit   <= 1'b0;
      word_done  <= 1'b0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow   <= 1'b0;
`endif
    end else begin
      diff_valid <= accept;
      diff_bit   <= accept & d;
      word_done  <= accept & msb_bit;
      if (accept) begin
        if (start_bit) begin
          state    <= RUN;
          cnt      <= CW'(1);
          borrow_q <= bout;
        end else if (msb_bit) begin
          state      <= IDLE;
          cnt        <= '0;
          borrow_q   <= 1'b0;
          borrow_out <= bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
          overflow   <= (a_bit != b_bit) & (d != a_bit);
`endif
        end else begin
          cnt      <= cnt + CW'(1);
          borrow_q <= bout;
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Scoreboard bench for serial_full_subtractor (WIDTH=8): stimulus pushes
// expected output bits, an independent monitor pops and compares them.
module tb_serial_full_subtractor;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_start = 1'b0;
  logic a_bit = 1'b0;
  logic b_bit = 1'b0;
  logic diff_valid, diff_bit, word_done, borrow_out, busy;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic overflow;
`endif

  serial_full_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_start   (in_start),
    .a_bit      (a_bit),
    .b_bit      (b_bit),
    .diff_valid (diff_valid),
    .diff_bit   (diff_bit),
    .word_done  (word_done),
    .borrow_out (borrow_out),
    .busy       (busy)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic d;
    logic wd;
    logic bo;
    logic ov;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output beat must match the oldest expectation, on time.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (diff_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got diff_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          n_cmp++;
          if (e.cyc != cyc) begin
            n_bad++;
            $display("FAIL out_timing: got cycle %0d expected cycle %0d", cyc, e.cyc);
          end
          chk("diff_bit", diff_bit, e.d);
          chk("word_done", word_done, e.wd);
          if (e.wd) begin
            chk("borrow_out", borrow_out, e.bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
            chk("overflow", overflow, e.ov);
`endif
          end
        end
      end else begin
        chk("diff_bit_idle", diff_bit, 1'b0);
        chk("word_done_idle", word_done, 1'b0);
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic a, input logic b);
    @(negedge clk);
    in_valid = v;
    in_start = s;
    a_bit    = a;
    b_bit    = b;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends nbits of a word; exp_d/eb/eo are hand-computed by the caller.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_d, input logic eb, input logic eo,
                           input int nbits, input logic [7:0] gap_after);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      drive(1'b1, i == 0, a[i], b[i]);
      e.d   = exp_d[i];
      e.wd  = (i == W - 1);
      e.bo  = eb;
      e.ov  = eo;
      e.cyc = cyc + 1;
      q.push_back(e);
      if (i == 2) chk("busy_mid_word", busy, 1'b1);
      if (gap_after[i]) idle(3);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_diff_valid", diff_valid, 1'b0);
    chk("rst_diff_bit", diff_bit, 1'b0);
    chk("rst_word_done", word_done, 1'b0);
    chk("rst_borrow_out", borrow_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_overflow", overflow, 1'b0);
`endif
    rst = 1'b0;

    // Non-start bits in IDLE are dropped.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);

    send_word(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 8, 8'h00);
    idle(2);
    chk("busy_after_word", busy, 1'b0);
    send_word(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 8, 8'h00);
    idle(1);
    send_word(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 8, 8'h00);
    idle(1);
    send_word(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 8, 8'b0010_0010);
    idle(1);
    send_word(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 8, 8'h00);
    idle(1);

    // Restart at bit 4, then a back-to-back word with no bubble.
    send_word(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 4, 8'h00);
    send_word(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1, 8'h00);
    @(posedge clk);
    #2;
    chk("borrow_held_on_restart", borrow_out, 1'b1);
    chk("busy_after_restart", busy, 1'b1);
    for (int i = 1; i < 8; i++) begin
      exp_t e;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      e.d = 1'b0; e.wd = (i == 7); e.bo = 1'b0; e.ov = 1'b0; e.cyc = cyc + 1;
      q.push_back(e);
    end
    send_word(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 8, 8'h00);
    idle(2);

    // Reset asserted while bit 3 is presented.
    send_word(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 3, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_start = 1'b0;
    a_bit = 1'b1;
    b_bit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rstmid_diff_valid", diff_valid, 1'b0);
    chk("rstmid_diff_bit", diff_bit, 1'b0);
    chk("rstmid_word_done", word_done, 1'b0);
    chk("rstmid_borrow_out", borrow_out, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    send_word(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 8, 8'h00);
    idle(3);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_outputs: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_full_subtractor.md
# serial_full_subtractor

Bit-serial, LSB-first two's-complement subtractor computing D = A − B over WIDTH-bit words, one bit per accepted cycle, with a registered borrow chain. It is the inverse-operation counterpart of the datapath's one-bit full adder cell. It sits beside the serial adders in the arithmetic stream path and consumes the same bit-stream framing (start-of-word marker plus per-bit valid).

## Interface
- WIDTH, 8, bits per word; legal range 2..64.
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  a_bit/b_bit carry a word bit this cycle.
- in_start  input  1  qualified by in_valid; marks bit 0 (LSB) of a new word.
- a_bit  input  1  minuend bit.
- b_bit  input  1  subtrahend bit.
- diff_valid  output  1  diff_bit valid this cycle.
- diff_bit  output  1  difference bit, LSB first.
- word_done  output  1  pulses with the MSB difference bit.
- borrow_out  output  1  final borrow of the word; valid while word_done=1, held until next word_done.
- busy  output  1  a word is in progress (state RUN).
- overflow  output  1  only with SERIAL_SUB_OVERFLOW_EN; signed overflow, same timing as borrow_out.

## Operation
- Bit cell: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
- States: IDLE, RUN.
- IDLE: bits with in_valid=1 and in_start=0 are dropped and produce no output. in_valid & in_start moves to RUN. That bit is processed with bin=0, and bit counter becomes 1.
- RUN: each in_valid=1 bit is processed with bin = borrow register, and the counter increments. When the processed bit is bit WIDTH−1, assert word_done, latch borrow_out = bout, and return to IDLE with the counter cleared.
- in_valid=0 in RUN: gap. Counter, borrow and state hold, and diff_valid=0. Gaps of any length are legal.
- in_start=1 in RUN (word restart): the partial word is abandoned without word_done. The bit is treated as bit 0 of a new word, with bin=0 and the counter set to 1. borrow_out is not updated.
- WIDTH words are back-to-back capable. A start bit in the cycle after the MSB is accepted with no bubble.
- borrow_out=1 iff unsigned A < B.

## Timing
- Latency: 1 cycle. An input bit accepted at edge k appears on diff_bit/diff_valid after edge k, valid for exactly one cycle.
- Throughput: 1 bit/cycle, with no backpressure. The block never stalls input.
- word_done, borrow_out and overflow update at the same edge as the MSB diff_bit.
- Reset values: diff_valid=0, diff_bit=0, word_done=0, borrow_out=0, busy=0, overflow=0, state=IDLE, counter=0, borrow register=0.
- rst has priority over all inputs. Reset mid-word discards the partial word, emits no word_done, and does not accept the input bit presented in the reset cycle.
- diff_bit is 0 whenever diff_valid=0.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined: the overflow port exists. It is latched at the MSB as (a_msb != b_msb) & (d_msb != a_msb), and it is cleared by reset only.
- SERIAL_SUB_OVERFLOW_EN undefined: the port and its MSB sign-capture register are absent. All other behaviour is identical.

## Structure
- Shared package serial_arith_pkg holds:
  - the state enum {IDLE, RUN};
  - the counter-width function clog2(WIDTH);
  - the default WIDTH constant, shared with the serial adders.
- Sub-module one_bit_full_subtractor: the combinational bit cell (a, b, bin → d, bout). It is instantiated once. The top level owns the FSM, counter, borrow register and output registers.

## Test plan
- WIDTH=8, A=0x05, B=0x03, contiguous → diff bits LSB-first 0,1,0,0,0,0,0,0 (0x02), word_done on 8th output, borrow_out=0.
- A=0x03, B=0x05 → 0xFE, borrow_out=1; with SERIAL_SUB_OVERFLOW_EN, overflow=0.
- A=0x80, B=0x01 → 0x7F, borrow_out=0, overflow=1; A=0x7F, B=0xFF → 0x80, borrow_out=1, overflow=1.
- A=0x10, B=0x01 with 3-cycle in_valid gaps after bits 1 and 5 → 0x0F, borrow chain preserved, diff_valid low during gaps, word_done with bit 7.
- Restart: in_start asserted at bit 4 of a word, followed by A=0x00, B=0x00 → no word_done for the aborted word; the new word yields 0x00 with borrow_out=0. A back-to-back second word with A=0x00, B=0x01 gives 0xFF with borrow_out=1 and no bubble.
- rst pulsed at bit 3 → all outputs 0 next cycle and busy=0. Non-start bits afterward are dropped. A fresh start word A=0x09, B=0x04 gives 0x05.
